uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one `transmit` UART serializer between NUM_REQ byte producers, such as the systolic-array result drain, a debug/status source and a host echo path.
- Accepts one word at a time from each requester through a valid/ready handshake and picks between requesters round-robin.
- Drives the serializer's en/start/in inputs and sequences one frame at a time using its busy/done outputs.
- A watchdog recovers the block if a frame never completes.

Parameters:
- BITS, 8, data word width; must match the serializer's `bits`.
- NUM_REQ, 4, number of requesters; must be at least 2.
- TIMEOUT, 64, maximum cycles from start issue to tx_done before the frame is abandoned; must be greater than BITS+4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*BITS  packed words; requester i occupies [i*BITS +: BITS].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_en  output  1  serializer enable.
- tx_start  output  1  serializer start request.
- tx_data  output  BITS  word presented to the serializer.
- tx_busy  input  1  serializer busy.
- tx_done  input  1  serializer frame-complete pulse.
- grant_id  output  clog2(NUM_REQ)  index of the requester that owns the current frame.
- active  output  1  high whenever the state is not IDLE.
- timeout_err  output  1  one-cycle pulse when a frame is abandoned.

Behaviour:
- Reset values (sync rst): state=IDLE, rr_ptr=0, req_ready=0, tx_en=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, wd_cnt=0.
- rst has priority in every state; rst mid-frame returns to IDLE in one cycle.
- No word is replayed after reset; the serializer's in-flight frame is ignored.
- All outputs are registered.

State machine:
- IDLE:
  - If any req_valid is high, select the first valid index scanning from rr_ptr upward with wrap-around.
  - Latch req_data[sel] into tx_data, set grant_id=sel, pulse req_ready[sel]=1 for exactly this one cycle, clear wd_cnt, go to ISSUE.
  - If no req_valid is high, stay in IDLE with all pulses at 0.
- ISSUE:
  - Drive tx_en=1 and tx_start=1; hold tx_data stable, because the serializer samples `in` one cycle after it sees start.
  - When tx_busy=1 is seen, clear tx_start (tx_en stays 1) and go to WAIT_DONE.
- WAIT_DONE:
  - Keep tx_data stable, tx_start=0 and tx_en=1.
  - On tx_done=1: set rr_ptr=(grant_id+1) mod NUM_REQ, set tx_en=0, go to IDLE.
- Watchdog:
  - wd_cnt increments every cycle in ISSUE and WAIT_DONE; width is clog2(TIMEOUT+1) and it saturates.
  - When wd_cnt==TIMEOUT-1 and tx_done has not been seen: pulse timeout_err, clear tx_start and tx_en, advance rr_ptr as on done, go to IDLE.

Timing and boundary rules:
- Latency: with the serializer idle, req_valid rising edge to tx_start high is 2 cycles; one cycle passes between frames before the next grant.
- tx_done arriving in the same cycle the watchdog expires counts as success, so no timeout_err is raised.
- A tx_done pulse seen in IDLE or ISSUE is ignored.
- A requester dropping req_valid before its grant has no effect; a word is committed only by its req_ready pulse.
- A requester holding req_valid after its ready pulse is treated as offering the next word.
- With all requesters valid, grants cycle 0,1,2,…,NUM_REQ-1,0; no requester waits for more than NUM_REQ-1 other frames.
- rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package uart_pkg holds:
  - arbiter state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2.
  - a function computing clog2-based widths.
  - the default BITS constant shared with the serializer.
- One sub-module, rr_pick: combinational round-robin selector with inputs valid vector and rr_ptr, outputs sel index and any_valid.
- The FSM, watchdog and data hold register live in uart_tx_arbiter.

Test Plan:
- Single word: after reset, req_valid=4'b0100 with word 8'hA5 → req_ready=4'b0100 pulses for one cycle, grant_id=2, tx_start high 2 cycles after valid. Serial line shows a start bit, LSB-first data 1,0,1,0,0,1,0,1, and a stop bit. tx_done returns the block to IDLE and rr_ptr becomes 3.
- Fairness: all four requesters continuously valid with words 8'h10..8'h13 for 8 frames → grant order 0,1,2,3,0,1,2,3. Exactly one req_ready bit is high per frame, and tx_data matches each granted word.
- Wrap and skip: rr_ptr=3, req_valid=4'b0011 → grant_id=0 then grant_id=1; requesters 2 and 3 are never granted.
- Timeout: model serializer raises tx_busy but never raises tx_done, TIMEOUT=64 → timeout_err pulses for exactly one cycle, 64 cycles after ISSUE entry. Outputs tx_en=0 and active=0 afterwards; the next requester is granted after that.
- Reset mid-frame: assert rst during WAIT_DONE → on the next cycle all outputs are at reset values and rr_ptr=0. After rst is released, a pending req_valid is granted normally.
- Done at expiry: tx_done arrives in the same cycle the watchdog expires → no timeout_err pulse; rr_ptr advances as for a normal completion.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// index-width helper and the default serializer word width.
package uart_pkg;

  localparam int unsigned UART_BITS = 32'd8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 32'd1;
    while ((32'd1 << w) < n) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index at or after the
// pointer, wrapping past the top requester back to zero.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 32'd4,
  parameter int unsigned IW      = idx_width(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_rr_ptr,
  output logic [IW-1:0]      o_sel,
  output logic               o_any_valid
);

  logic [IW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    o_sel       = '0;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx       = IW'((32'(i_rr_ptr) + 32'(k)) % NUM_REQ);
      o_sel       = i_valid[w_idx] ? w_idx : o_sel;
      o_any_valid = o_any_valid | i_valid[w_idx];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer between NUM_REQ producers,
// with a watchdog that abandons frames whose done pulse never arrives.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned BITS    = UART_BITS,
  parameter int unsigned NUM_REQ = 32'd4,
  parameter int unsigned TIMEOUT = 32'd64
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BITS-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_en,
  output logic                          tx_start,
  output logic [BITS-1:0]               tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [idx_width(NUM_REQ)-1:0] grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int unsigned        IW       = idx_width(NUM_REQ);
  localparam int unsigned        WW       = idx_width(TIMEOUT + 32'd1);
  localparam logic [WW-1:0]      WD_LAST  = WW'(TIMEOUT - 32'd1);
  localparam logic [IW-1:0]      PTR_LAST = IW'(NUM_REQ - 32'd1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant_id;
  logic [WW-1:0]      r_wd_cnt;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_tx_en;
  logic               r_tx_start;
  logic [BITS-1:0]    r_tx_data;
  logic               r_active;
  logic               r_timeout_err;

  logic [BITS-1:0]    w_words [NUM_REQ];
  logic [IW-1:0]      w_sel;
  logic               w_any_valid;
  logic [IW-1:0]      w_ptr_next;
  logic [WW-1:0]      w_wd_next;
  logic               w_wd_expire;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = req_data[g*BITS +: BITS];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .i_valid     (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_sel       (w_sel),
    .o_any_valid (w_any_valid)
  );

  // Pointer advance past the current owner, saturating watchdog and expiry.
  always_comb begin
    w_ptr_next  = (r_grant_id == PTR_LAST) ? '0 : r_grant_id + IW'(1'b1);
    w_wd_next   = (r_wd_cnt == {WW{1'b1}}) ? r_wd_cnt : r_wd_cnt + WW'(1'b1);
    w_wd_expire = (r_wd_cnt == WD_LAST);
  end

  // Arbitration FSM, watchdog and registered serializer controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_wd_cnt      <= '0;
      r_req_ready   <= '0;
      r_tx_en       <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_en    <= 1'b0;
          r_tx_start <= 1'b0;
          r_wd_cnt   <= '0;
          if (w_any_valid) begin
            r_tx_data   <= w_words[w_sel];
            r_grant_id  <= w_sel;
            r_req_ready <= ONE_HOT0 << w_sel;
            r_active    <= 1'b1;
            r_state     <= ISSUE;
          end else begin
            r_active <= 1'b0;
          end
        end
        ISSUE: begin
          r_wd_cnt <= w_wd_next;
          if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
            r_tx_en       <= 1'b0;
            r_tx_start    <= 1'b0;
            r_rr_ptr      <= w_ptr_next;
            r_active      <= 1'b0;
            r_state       <= IDLE;
          end else if (tx_busy) begin
            r_tx_en    <= 1'b1;
            r_tx_start <= 1'b0;
            r_state    <= WAIT_DONE;
          end else begin
            r_tx_en    <= 1'b1;
            r_tx_start <= 1'b1;
          end
        end
        WAIT_DONE: begin
          r_wd_cnt   <= w_wd_next;
          r_tx_start <= 1'b0;
          // A done landing on the expiry cycle still counts as a completed frame.
          if (tx_done) begin
            r_tx_en  <= 1'b0;
            r_rr_ptr <= w_ptr_next;
            r_active <= 1'b0;
            r_state  <= IDLE;
          end else if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
            r_tx_en       <= 1'b0;
            r_rr_ptr      <= w_ptr_next;
            r_active      <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_tx_en <= 1'b1;
          end
        end
        default: begin
          r_tx_en    <= 1'b0;
          r_tx_start <= 1'b0;
          r_active   <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_en       = r_tx_en;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign active      = r_active;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues, a one-bit-per-cycle
// serializer model, a grant monitor and a serial-line receiver.
module tb_uart_tx_arbiter;

  localparam int BITS = 8;
  localparam int NR   = 4;
  localparam int TO   = 64;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } gnt_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_en, tx_start, tx_busy, tx_done;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;
  logic            active, timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;

  gnt_t       exp_g[$];
  logic [7:0] exp_frm[$];
  logic [7:0] src_q[NR][$];

  logic       hang;
  logic       man_done;
  logic       m_pend, m_busy, m_done, m_line;
  logic [8:0] m_sh;
  logic [3:0] m_cnt;
  int         rx_cnt;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter #(.BITS(BITS), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id), .active(active),
    .timeout_err(timeout_err)
  );

  assign tx_busy = m_busy;
  assign tx_done = m_done | man_done;

  // Serializer model: samples tx_data one cycle after start, shifts start,
  // 8 data bits LSB-first and stop, then pulses done. In hang mode no done.
  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_line <= 1'b1;
      m_cnt <= 4'd0; m_sh <= 9'd0;
    end else begin
      m_done <= 1'b0;
      if (m_pend) begin
        m_pend <= 1'b0;
        m_busy <= 1'b1;
        m_sh   <= {1'b1, tx_data};
        m_cnt  <= 4'd0;
        if (!hang) m_line <= 1'b0;
      end else if (m_busy) begin
        if (!tx_en) begin
          m_busy <= 1'b0;
          m_line <= 1'b1;
        end else if (!hang) begin
          if (m_cnt == 4'd9) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_line <= 1'b1;
          end else begin
            m_line <= m_sh[0];
            m_sh   <= m_sh >> 1;
            m_cnt  <= m_cnt + 4'd1;
          end
        end
      end else if (tx_en && tx_start) begin
        m_pend <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int id, input logic [7:0] d, input bit frame);
    gnt_t g;
    g.id   = 2'(id);
    g.data = d;
    exp_g.push_back(g);
    if (frame) exp_frm.push_back(d);
    src_q[id].push_back(d);
  endtask

  task automatic wait_high(input string name, input int which, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      case (which)
        0:       hit = tx_start;
        1:       hit = active;
        2:       hit = timeout_err;
        default: hit = tx_en && !tx_start && active;
      endcase
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL wait_%s: not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      hit = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
            (src_q[2].size() == 0) && (src_q[3].size() == 0) &&
            (exp_g.size() == 0) && (exp_frm.size() == 0) && !active &&
            !m_busy && !m_pend && (rx_cnt == 0);
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL idle_%s: not idle within %0d cycles (grants left %0d, frames left %0d)",
               name, budget, exp_g.size(), exp_frm.size());
    end
  endtask

  // Requester driver: a word leaves its queue only on its ready pulse.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        req_valid[i]        = (src_q[i].size() != 0);
        req_data[i*8 +: 8]  = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  // Grant monitor: every ready pulse is matched against the next expected grant.
  initial begin
    gnt_t       e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (!rst && (req_ready != 4'b0000)) begin
        if (exp_g.size() == 0) begin
          chk("grant_unexpected", 32'(req_ready), 32'd0);
        end else begin
          e  = exp_g.pop_front();
          oh = 4'b0001 << e.id;
          chk("grant_ready", 32'(req_ready), 32'(oh));
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("grant_data", 32'(tx_data), 32'(e.data));
        end
      end
    end
  end

  // Serial receiver: decodes frames from the model's line and checks them.
  initial begin
    rx_cnt  = 0;
    rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_cnt = 0;
      end else if (rx_cnt == 0) begin
        if (m_line == 1'b0) rx_cnt = 1;
      end else if (rx_cnt <= 8) begin
        rx_byte[rx_cnt-1] = m_line;
        rx_cnt++;
      end else begin
        chk("stop_bit", 32'(m_line), 32'd1);
        chk("frame_queue", 32'(exp_frm.size() != 0), 32'd1);
        if (exp_frm.size() != 0) chk("frame_byte", 32'(rx_byte), 32'(exp_frm.pop_front()));
        rx_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit to_seen;
    rst = 1'b1; hang = 1'b0; man_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single word from requester 2, start latency of two cycles.
    t0 = cyc;
    expect_word(2, 8'hA5, 1'b1);
    wait_high("start", 0, 20);
    chk("start_latency", 32'(cyc - t0), 32'd2);
    wait_idle("single", 200);
    chk("single_tx_en_off", 32'(tx_en), 32'd0);

    // Pointer now at 3: requester 3 first, then 1, then 2.
    @(posedge clk); #1;
    expect_word(3, 8'h3A, 1'b1);
    expect_word(1, 8'h1A, 1'b1);
    expect_word(2, 8'h2A, 1'b1);
    wait_idle("ptr3", 300);

    // Wrap and skip: pointer 3 with requesters 0 and 1 valid.
    @(posedge clk); #1;
    expect_word(0, 8'h3C, 1'b1);
    expect_word(1, 8'hC3, 1'b1);
    wait_idle("wrap", 300);

    // Reset mid-frame; pending requesters 1 and 3 then served from pointer 0.
    @(posedge clk); #1;
    expect_word(2, 8'h5A, 1'b0);
    expect_word(1, 8'h11, 1'b1);
    expect_word(3, 8'h33, 1'b1);
    wait_high("wait_done", 3, 40);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_tx_en", 32'(tx_en), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    rst = 1'b0;
    wait_idle("after_rst", 300);

    // Fairness: all four continuously valid for eight frames.
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        expect_word(i, 8'h10 + 8'(i), 1'b1);
    wait_idle("fair", 600);

    // Timeout: frame from requester 1 never completes.
    @(posedge clk); #1;
    hang = 1'b1;
    expect_word(1, 8'hE1, 1'b0);
    expect_word(3, 8'h3F, 1'b1);
    expect_word(1, 8'hE2, 1'b1);
    wait_high("active_to", 1, 20);
    t0 = cyc;
    wait_high("timeout_err", 2, 200);
    chk("timeout_delay", 32'(cyc - t0), 32'd64);
    chk("timeout_tx_en", 32'(tx_en), 32'd0);
    chk("timeout_active", 32'(active), 32'd0);
    hang = 1'b0;
    @(negedge clk);
    chk("timeout_pulse_width", 32'(timeout_err), 32'd0);
    wait_idle("timeout", 300);

    // Done arriving on the watchdog's last cycle is a normal completion.
    @(posedge clk); #1;
    hang = 1'b1;
    expect_word(2, 8'h99, 1'b0);
    expect_word(3, 8'h43, 1'b1);
    expect_word(2, 8'h9A, 1'b1);
    wait_high("active_exp", 1, 20);
    repeat (TO - 1) @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("expiry_done_idle", 32'(active), 32'd0);
    to_seen = timeout_err;
    repeat (4) begin
      @(negedge clk);
      to_seen = to_seen | timeout_err;
    end
    chk("expiry_done_no_timeout", 32'(to_seen), 32'd0);
    wait_idle("expiry", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
